// File: rtl/iram_arb_pkg.sv
// iram_arb_pkg: shared types and defaults for the IRAM arbiter.
//   port_e      - requester identity (PORT0 = LCD_CTRL write-back, PORT1 = dump host)
//   DW/AW/BURST_MAX defaults, CNT_W (stats counter width), BCNT_W (burst counter width)
//   other()     - returns the opposite port
package iram_arb_pkg;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned AW_DEF        = 6;
    localparam int unsigned BURST_MAX_DEF = 8;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned BCNT_W        = 8;

    function automatic port_e other(input port_e p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/iram_arb_rr.sv
// iram_arb_rr: round-robin grant with bounded burst locking.
//   clk, rst           - clock, synchronous active-low reset
//   m0_req, m1_req     - access requests
//   m0_lock, m1_lock   - burst lock requests
//   gnt                - combinational: some port is granted at this posedge
//   gnt_port           - which port is granted (valid when gnt)
// State: last granted port, lock flag/owner, consecutive-grant count (bcnt).
module iram_arb_rr
    import iram_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  m0_req,
    input  logic  m1_req,
    input  logic  m0_lock,
    input  logic  m1_lock,
    output logic  gnt,
    output port_e gnt_port
);

    port_e             last_q;
    port_e             lock_port_q;
    logic              lock_q;
    logic [BCNT_W-1:0] bcnt_q;

    logic own_req;
    logic own_lock;
    logic lock_eff;
    logic gnt_lock;

    always_comb begin
        own_req  = (lock_port_q == PORT0) ? m0_req  : m1_req;
        own_lock = (lock_port_q == PORT0) ? m0_lock : m1_lock;
        // Lock lapses the moment its owner stops requesting or drops lock.
        lock_eff = lock_q & own_req & own_lock;

        gnt      = 1'b0;
        gnt_port = PORT0;
        if (rst) begin
            if (m0_req && m1_req) begin
                gnt = 1'b1;
                if (lock_eff) begin
                    // >= also covers a count built up while the owner was alone.
                    gnt_port = (bcnt_q >= BCNT_W'(BURST_MAX)) ? other(lock_port_q)
                                                                : lock_port_q;
                end else begin
                    gnt_port = other(last_q);
                end
            end else if (m0_req) begin
                gnt      = 1'b1;
                gnt_port = PORT0;
            end else if (m1_req) begin
                gnt      = 1'b1;
                gnt_port = PORT1;
            end
        end
        gnt_lock = (gnt_port == PORT0) ? m0_lock : m1_lock;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q      <= PORT1;
            lock_port_q <= PORT0;
            lock_q      <= 1'b0;
            bcnt_q      <= '0;
        end else if (gnt) begin
            last_q      <= gnt_port;
            lock_port_q <= gnt_port;
            lock_q      <= gnt_lock;
            if (gnt_port != last_q) begin
                bcnt_q <= BCNT_W'(1);
            end else if (bcnt_q != '1) begin
                bcnt_q <= bcnt_q + BCNT_W'(1);
            end
        end else begin
            lock_q <= 1'b0;
        end
    end

endmodule

// File: rtl/iram_arb.sv
// iram_arb: two-port arbiter in front of the single-port 64x8 IRAM.
//   clk, rst                  - clock, synchronous active-low reset
//   mX_req/lock/we/addr/wdata - requester command (X = 0: LCD_CTRL, 1: dump host)
//   mX_gnt                    - combinational grant, access accepted at this posedge
//   mX_rvalid                 - read data valid for port X (2 cycles after gnt)
//   rdata                     - IRAM_Q passthrough
//   IRAM_ceb/web/A/D          - registered IRAM controls, IRAM_Q read data in
// Optional: define IRAM_ARB_STATS_EN to add m0_cnt/m1_cnt saturating grant counters.
module iram_arb
    import iram_arb_pkg::*;
#(
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          IRAM_ceb,
    output logic          IRAM_web,
    output logic [AW-1:0] IRAM_A,
    output logic [DW-1:0] IRAM_D,
    input  logic [DW-1:0] IRAM_Q
`ifdef IRAM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] m0_cnt,
    output logic [CNT_W-1:0] m1_cnt
`endif
);

    logic          gnt;
    port_e         gnt_port;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    port_e         st1_port;
    port_e         rd_port;
    logic          rd_valid;

    iram_arb_rr #(
        .BURST_MAX(BURST_MAX)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req),
        .m1_req  (m1_req),
        .m0_lock (m0_lock),
        .m1_lock (m1_lock),
        .gnt     (gnt),
        .gnt_port(gnt_port)
    );

    always_comb begin
        m0_gnt    = gnt & (gnt_port == PORT0);
        m1_gnt    = gnt & (gnt_port == PORT1);
        sel_we    = (gnt_port == PORT0) ? m0_we    : m1_we;
        sel_addr  = (gnt_port == PORT0) ? m0_addr  : m1_addr;
        sel_wdata = (gnt_port == PORT0) ? m0_wdata : m1_wdata;
    end

    // Stage 1 drives the macro; stage 2 tags the returning read with its port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            IRAM_ceb <= 1'b0;
            IRAM_web <= 1'b1;
            IRAM_A   <= '0;
            IRAM_D   <= '0;
            st1_port <= PORT0;
            rd_valid <= 1'b0;
            rd_port  <= PORT0;
        end else begin
            if (gnt) begin
                IRAM_ceb <= 1'b1;
                IRAM_web <= ~sel_we;
                IRAM_A   <= sel_addr;
                IRAM_D   <= sel_wdata;
                st1_port <= gnt_port;
            end else begin
                IRAM_ceb <= 1'b0;
            end
            rd_valid <= IRAM_ceb & IRAM_web;
            rd_port  <= st1_port;
        end
    end

    always_comb begin
        m0_rvalid = rd_valid & (rd_port == PORT0);
        m1_rvalid = rd_valid & (rd_port == PORT1);
        rdata     = IRAM_Q;
    end

`ifdef IRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            m0_cnt <= '0;
            m1_cnt <= '0;
        end else begin
            if (m0_gnt && (m0_cnt != '1)) m0_cnt <= m0_cnt + CNT_W'(1);
            if (m1_gnt && (m1_cnt != '1)) m1_cnt <= m1_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_iram_arb.sv
// tb_iram_arb: self-checking bench for iram_arb with a behavioural IRAM macro.
// Read expectations are queued at grant time and checked when rvalid returns.
// Stats checks are compiled in when IRAM_ARB_STATS_EN is defined.
module tb_iram_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
    logic [5:0] m0_addr = '0;
    logic [7:0] m0_wdata = '0;
    logic       m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
    logic [5:0] m1_addr = '0;
    logic [7:0] m1_wdata = '0;
    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [7:0] rdata;
    logic       IRAM_ceb, IRAM_web;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic [7:0] IRAM_Q;
`ifdef IRAM_ARB_STATS_EN
    logic [15:0] m0_cnt, m1_cnt;
`endif

    iram_arb #(
        .DW(8),
        .AW(6),
        .BURST_MAX(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_lock  (m0_lock),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m1_req   (m1_req),
        .m1_lock  (m1_lock),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m0_gnt   (m0_gnt),
        .m1_gnt   (m1_gnt),
        .m0_rvalid(m0_rvalid),
        .m1_rvalid(m1_rvalid),
        .rdata    (rdata),
        .IRAM_ceb (IRAM_ceb),
        .IRAM_web (IRAM_web),
        .IRAM_A   (IRAM_A),
        .IRAM_D   (IRAM_D),
        .IRAM_Q   (IRAM_Q)
`ifdef IRAM_ARB_STATS_EN
        ,
        .m0_cnt   (m0_cnt),
        .m1_cnt   (m1_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port IRAM: Q valid the cycle after the access cycle.
    logic [7:0] iram_mem [0:63];
    logic [7:0] iram_q;
    always @(posedge clk) begin
        if (IRAM_ceb) begin
            if (!IRAM_web) iram_mem[IRAM_A] <= IRAM_D;
            else           iram_q <= iram_mem[IRAM_A];
        end
    end
    assign IRAM_Q = iram_q;

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] ref_mem [0:63];
    int         cyc = 0;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    logic       g0, g1, s_ceb, s_web;
    logic [5:0] s_A;
    logic [7:0] s_D;
    logic [1:0] s_rv;

    // One clock: sample at negedge, score returning reads, log new grants,
    // then advance to just after the next posedge.
    task automatic step();
        exp_t       e;
        logic       due;
        logic [1:0] exp_rv;
        @(negedge clk);
        g0 = m0_gnt; g1 = m1_gnt;
        s_ceb = IRAM_ceb; s_web = IRAM_web; s_A = IRAM_A; s_D = IRAM_D;
        s_rv = {m0_rvalid, m1_rvalid};
        due = (sbq.size() > 0) && (sbq[0].due == cyc);
        if (due || s_rv != 2'b00) begin
            chk_cnt++;
            exp_rv = 2'b00;
            e.data = 8'h00;
            if (due) begin
                e = sbq.pop_front();
                exp_rv = e.port ? 2'b01 : 2'b10;
            end
            if (s_rv !== exp_rv || (due && rdata !== e.data))
                $display("FAIL rvalid cyc=%0d got rv(m0,m1)=%b rdata=%h want rv=%b rdata=%h",
                         cyc, s_rv, rdata, exp_rv, e.data);
            else
                pass_cnt++;
        end
        if (!rst) sbq.delete();
        if (g0) begin
            if (m0_we) ref_mem[m0_addr] = m0_wdata;
            else sbq.push_back('{1'b0, ref_mem[m0_addr], cyc + 2});
        end
        if (g1) begin
            if (m1_we) ref_mem[m1_addr] = m1_wdata;
            else sbq.push_back('{1'b1, ref_mem[m1_addr], cyc + 2});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_all();
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        step();
        step();
        chk_cnt++;
        if ({g0, g1} !== 2'b00) $display("FAIL reset_gnt got %b%b want 00", g0, g1);
        else pass_cnt++;
        chk_cnt++;
        if (s_ceb !== 1'b0) $display("FAIL reset_ceb got %b want 0", s_ceb);
        else pass_cnt++;
        chk_cnt++;
        if (s_web !== 1'b1) $display("FAIL reset_web got %b want 1", s_web);
        else pass_cnt++;
        chk_cnt++;
        if (s_A !== 6'h00 || s_D !== 8'h00) $display("FAIL reset_AD got A=%h D=%h want 00 00", s_A, s_D);
        else pass_cnt++;
        chk_cnt++;
        if (s_rv !== 2'b00) $display("FAIL reset_rvalid got %b want 00", s_rv);
        else pass_cnt++;
        idle_all();
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'h05; m0_wdata = 8'hA5;
        step();
        chk_cnt++;
        if ({g0, g1} !== 2'b10) $display("FAIL wr_gnt got %b%b want 10", g0, g1);
        else pass_cnt++;
        m0_we = 1'b0;
        step();
        chk_cnt++;
        if ({s_ceb, s_web, s_A, s_D} !== {1'b1, 1'b0, 6'h05, 8'hA5})
            $display("FAIL wr_iram got ceb=%b web=%b A=%h D=%h want 1 0 05 a5", s_ceb, s_web, s_A, s_D);
        else pass_cnt++;
        chk_cnt++;
        if ({g0, g1} !== 2'b10) $display("FAIL rd_gnt got %b%b want 10", g0, g1);
        else pass_cnt++;
        m0_req = 1'b0;
        step();
        chk_cnt++;
        if ({s_ceb, s_web, s_A} !== {1'b1, 1'b1, 6'h05})
            $display("FAIL rd_iram got ceb=%b web=%b A=%h want 1 1 05", s_ceb, s_web, s_A);
        else pass_cnt++;
        step();
        step();
        // Back-to-back writes from m1 to seed addresses 0..7.
        m1_req = 1'b1; m1_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m1_addr = 6'(i);
            m1_wdata = 8'(8'h30 + i);
            step();
            chk_cnt++;
            if ({g0, g1} !== 2'b01) $display("FAIL m1_wr_gnt[%0d] got %b%b want 01", i, g0, g1);
            else pass_cnt++;
        end
        m1_req = 1'b0; m1_we = 1'b0;
        step();
    endtask

    task automatic test_alternate();
        do_reset();
        m0_we = 1'b0; m1_we = 1'b0; m0_addr = 6'h01; m1_addr = 6'h02;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_cnt++;
            if ({g0, g1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL alt_gnt[%0d] got %b%b want %b", i, g0, g1, (i % 2 == 0) ? 2'b10 : 2'b01);
            else pass_cnt++;
        end
        idle_all();
        repeat (3) step();
    endtask

    task automatic test_lock();
        logic [1:0] exp;
        do_reset();
        m0_we = 1'b0; m1_we = 1'b0; m0_addr = 6'h02; m1_addr = 6'h03;
        m0_req = 1'b1; m0_lock = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
            exp = (i == 8 || i == 17) ? 2'b01 : 2'b10;
            chk_cnt++;
            if ({g0, g1} !== exp) $display("FAIL lock_gnt[%0d] got %b%b want %b", i, g0, g1, exp);
            else pass_cnt++;
        end
        idle_all();
        repeat (3) step();
    endtask

    task automatic test_lock_drop();
        logic [1:0] exp;
        do_reset();
        m0_we = 1'b0; m1_we = 1'b0; m0_addr = 6'h06; m1_addr = 6'h04;
        m1_req = 1'b1; m1_lock = 1'b1; m0_lock = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 2) m0_req = 1'b1;
            if (i == 4) m1_req = 1'b0;
            if (i == 5) begin m1_req = 1'b1; m1_lock = 1'b0; end
            step();
            // m1 holds until it drops; then m0 runs a full fresh burst of 8.
            exp = (i < 4 || i == 12) ? 2'b01 : 2'b10;
            chk_cnt++;
            if ({g0, g1} !== exp) $display("FAIL lockdrop_gnt[%0d] got %b%b want %b", i, g0, g1, exp);
            else pass_cnt++;
        end
        idle_all();
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_we = 1'b0; m0_addr = 6'h05; m0_req = 1'b1;
        step();
        chk_cnt++;
        if ({g0, g1} !== 2'b10) $display("FAIL rstmid_gnt got %b%b want 10", g0, g1);
        else pass_cnt++;
        rst = 1'b0;
        step();
        chk_cnt++;
        if ({g0, g1} !== 2'b00) $display("FAIL rstmid_gnt_in_reset got %b%b want 00", g0, g1);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (s_ceb !== 1'b0 || s_rv !== 2'b00)
            $display("FAIL rstmid_drop got ceb=%b rv=%b want 0 00", s_ceb, s_rv);
        else pass_cnt++;
        rst = 1'b1;
        idle_all();
        repeat (3) step();
    endtask

`ifdef IRAM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        m0_we = 1'b1; m0_addr = 6'h10; m0_wdata = 8'h11; m0_req = 1'b1;
        repeat (100) step();
        chk_cnt++;
        if (m0_cnt !== 16'd100) $display("FAIL stats_m0_100 got %0d want 100", m0_cnt);
        else pass_cnt++;
        repeat (69900) step();
        chk_cnt++;
        if (m0_cnt !== 16'hFFFF) $display("FAIL stats_m0_sat got %h want ffff", m0_cnt);
        else pass_cnt++;
        m0_req = 1'b0;
        m1_we = 1'b1; m1_addr = 6'h11; m1_wdata = 8'h22; m1_req = 1'b1;
        repeat (5) step();
        m0_req = 1'b1;
        repeat (4) step();
        idle_all();
        step();
        chk_cnt++;
        if (m1_cnt !== 16'd7) $display("FAIL stats_m1 got %0d want 7", m1_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (m0_cnt !== 16'hFFFF) $display("FAIL stats_m0_hold got %h want ffff", m0_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_lock();
        test_lock_drop();
        test_reset_mid();
`ifdef IRAM_ARB_STATS_EN
        test_stats();
`endif
        repeat (3) step();
        chk_cnt++;
        if (sbq.size() !== 0) $display("FAIL sb_empty got %0d pending reads want 0", sbq.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
